// File: rtl/avalon_mm_reader.sv
// Avalon-MM burst-less read master that streams a job of beats to a
// valid/ready sink.
//
// A job starts on a one-cycle start pulse in IDLE. The module then issues
// single-beat reads from base_addr, stepping by BEAT_W/8 bytes, until
// beat_count reads have been accepted. Responses land in a DEPTH-entry FIFO
// and are presented on m_valid/m_data. Reads are only issued while
// outstanding reads plus buffered beats stay below DEPTH, so a response
// always has a free slot.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 begin a job (honoured in IDLE only)
//   base_addr, beat_count job parameters, sampled on an accepted start
//   busy, done            READ-state flag, one-cycle completion pulse
//   m_valid, m_ready      output stream handshake
//   m_data, m_last        output beat and final-beat marker
//   avm_address, avm_read, avm_burstcount       Avalon read request
//   avm_waitrequest                             slave stall
//   avm_readdata, avm_readdatavalid             Avalon read response
module avalon_mm_reader #(
  parameter int unsigned BEAT_W = 128,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LEN_W  = 16,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  beat_count,
  output logic              busy,
  output logic              done,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [BEAT_W-1:0] m_data,
  output logic              m_last,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic [7:0]        avm_burstcount,
  input  logic              avm_waitrequest,
  input  logic [BEAT_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned BYTES = BEAT_W / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Job bookkeeping
  logic [LEN_W-1:0]  beat_len;
  logic [LEN_W-1:0]  issued;
  logic [LEN_W-1:0]  delivered;
  logic [CNT_W-1:0]  inflight;

  // Response FIFO
  logic [BEAT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt;

  // Per-cycle events and next values
  logic              accept_start;
  logic              rd_accept;
  logic              push;
  logic              pop;
  logic              credit_ok;
  logic [LEN_W-1:0]  beat_len_n;
  logic [LEN_W-1:0]  issued_n;
  logic [LEN_W-1:0]  delivered_n;
  logic [CNT_W-1:0]  inflight_n;
  logic [CNT_W-1:0]  fifo_cnt_n;
  logic [CNT_W-1:0]  cnt_left;
  logic [PTR_W-1:0]  wr_ptr_n;
  logic [PTR_W-1:0]  rd_ptr_n;

  // Next values of registered outputs
  logic              busy_d;
  logic              done_d;
  logic              avm_read_d;
  logic [ADDR_W-1:0] avm_address_d;
  logic              m_valid_d;
  logic              m_last_d;
  logic [BEAT_W-1:0] m_data_d;

  assign avm_burstcount = 8'd1;

  // Handshake events and counter/pointer next values.
  // A response with nothing outstanding (stale or spurious) is dropped.
  always_comb begin
    accept_start = start && (state == S_IDLE);
    rd_accept    = avm_read && !avm_waitrequest;
    push         = avm_readdatavalid && (inflight != '0);
    pop          = m_valid && m_ready;

    beat_len_n   = accept_start ? beat_count : beat_len;
    issued_n     = accept_start ? '0 : issued + LEN_W'(rd_accept);
    delivered_n  = accept_start ? '0 : delivered + LEN_W'(pop);
    inflight_n   = accept_start ? '0
                                : inflight + CNT_W'(rd_accept) - CNT_W'(push);

    fifo_cnt_n   = fifo_cnt + CNT_W'(push) - CNT_W'(pop);
    cnt_left     = fifo_cnt - CNT_W'(pop);
    wr_ptr_n     = wr_ptr + PTR_W'(push);
    rd_ptr_n     = rd_ptr + PTR_W'(pop);

    credit_ok    = (SUM_W'(inflight_n) + SUM_W'(fifo_cnt_n)) < SUM_W'(DEPTH);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; READ ends on the cycle the final beat pops
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = (beat_count == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        if (delivered_n == beat_len) begin
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic: next values for the registered outputs
  always_comb begin
    busy_d        = (state_next == S_READ);
    done_d        = (state_next == S_DONE);

    // A stalled request is held unchanged; otherwise issue while reads
    // remain and a buffer slot is guaranteed for the response.
    avm_read_d    = 1'b0;
    if (state_next == S_READ) begin
      avm_read_d = (avm_read && avm_waitrequest) ||
                   ((issued_n < beat_len_n) && credit_ok);
    end

    avm_address_d = avm_address;
    if (accept_start) begin
      avm_address_d = base_addr;
    end else if (rd_accept) begin
      avm_address_d = avm_address + ADDR_W'(BYTES);
    end

    m_valid_d     = (fifo_cnt_n != '0);
    m_last_d      = m_valid_d && (delivered_n == (beat_len_n - LEN_W'(1)));

    // Head of the FIFO after this cycle: the incoming beat if the FIFO
    // drains to empty, otherwise the entry at the advanced read pointer.
    m_data_d      = m_data;
    if (cnt_left == '0) begin
      if (push) begin
        m_data_d = avm_readdata;
      end
    end else begin
      m_data_d = mem[rd_ptr_n];
    end
  end

  // Registered outputs, counters and FIFO pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      avm_read    <= 1'b0;
      avm_address <= '0;
      m_valid     <= 1'b0;
      m_last      <= 1'b0;
      m_data      <= '0;
      beat_len    <= '0;
      issued      <= '0;
      delivered   <= '0;
      inflight    <= '0;
      fifo_cnt    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      busy        <= busy_d;
      done        <= done_d;
      avm_read    <= avm_read_d;
      avm_address <= avm_address_d;
      m_valid     <= m_valid_d;
      m_last      <= m_last_d;
      m_data      <= m_data_d;
      beat_len    <= beat_len_n;
      issued      <= issued_n;
      delivered   <= delivered_n;
      inflight    <= inflight_n;
      fifo_cnt    <= fifo_cnt_n;
      wr_ptr      <= wr_ptr_n;
      rd_ptr      <= rd_ptr_n;
    end
  end

  // FIFO storage; contents are qualified by fifo_cnt so no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= avm_readdata;
    end
  end

endmodule
